// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the single-master system-bus interconnect.
package sys_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } state_t;

  typedef struct packed {
    logic              rdwr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] mask;
  } req_t;

endpackage

// File: rtl/sys_bus_addr_decode.sv
// Combinational tag match: priority-encodes to a one-hot select (lowest index wins).
// Zero latency; no handshake, unmapped_o flags an address with no matching tag.
module sys_bus_addr_decode
  import sys_bus_pkg::*;
#(
  parameter int                        N_SLAVES   = 4,
  parameter int                        TW         = 4,
  parameter logic [N_SLAVES*TW-1:0]    SLAVE_TAGS = 16'h9820
) (
  input  logic [TW-1:0]       tag_i,
  output logic [N_SLAVES-1:0] sel_o,
  output logic                unmapped_o
);

  logic hit;

  always_comb begin
    sel_o = '0;
    hit   = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit && (tag_i == SLAVE_TAGS[i*TW +: TW])) begin
        sel_o[i] = 1'b1;
        hit      = 1'b1;
      end
    end
    unmapped_o = !hit;
  end

endmodule

// File: rtl/sys_bus_interconnect.sv
// Single-master/N-slave bus: one outstanding request, completes 1+k cycles after acceptance (ack k after ISSUE).
// Master stalls while m_busy; unmapped/timeout return ERR_DATA with m_err. Optional error log: SYS_BUS_ERR_LOG_EN.
module sys_bus_interconnect
  import sys_bus_pkg::*;
#(
  parameter int                                      N_SLAVES    = 4,
  parameter int                                      TAG_HI      = 31,
  parameter int                                      TAG_LO      = 28,
  parameter logic [N_SLAVES*(TAG_HI-TAG_LO+1)-1:0]   SLAVE_TAGS  = 16'h9820,
  parameter int                                      TIMEOUT_CYC = 64,
  parameter logic [DATA_W-1:0]                       ERR_DATA    = ERR_DATA_DFLT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_en,
  input  logic                       m_rdwr,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wr_data,
  input  logic [MASK_W-1:0]          m_mask,
  output logic [DATA_W-1:0]          m_rd_data,
  output logic                       m_ready,
  output logic                       m_err,
  output logic                       m_busy,
  output logic [N_SLAVES-1:0]        s_en,
  output logic                       s_rdwr,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wr_data,
  output logic [MASK_W-1:0]          s_mask,
  input  logic [DATA_W*N_SLAVES-1:0] s_rd_data,
  input  logic [N_SLAVES-1:0]        s_ack
`ifdef SYS_BUS_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]          err_addr,
  output logic                       err_cause,
  output logic                       err_valid,
  input  logic                       err_clr
`endif
);

  localparam int TW    = TAG_HI - TAG_LO + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state_q;
  req_t                req_q, req_d;
  logic [N_SLAVES-1:0] sel_q, s_en_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [N_SLAVES-1:0] dec_sel;
  logic                dec_unmapped;
  logic                ack_hit, tmo_hit, err_done;
  logic [DATA_W-1:0]   rd_mux;

  sys_bus_addr_decode #(
    .N_SLAVES   (N_SLAVES),
    .TW         (TW),
    .SLAVE_TAGS (SLAVE_TAGS)
  ) u_decode (
    .tag_i      (m_addr[TAG_HI:TAG_LO]),
    .sel_o      (dec_sel),
    .unmapped_o (dec_unmapped)
  );

  // Word-align the address at capture so the broadcast copy needs no extra logic.
  always_comb begin
    req_d.rdwr    = m_rdwr;
    req_d.addr    = {m_addr[ADDR_W-1:2], 2'b00};
    req_d.wr_data = m_wr_data;
    req_d.mask    = m_mask;
  end

  // An ack in the final timeout cycle still wins over the error.
  assign ack_hit  = (state_q == WAIT) && (|(s_ack & sel_q));
  assign tmo_hit  = (state_q == WAIT) && !ack_hit && (cnt_q == CNT_LAST);
  assign err_done = (state_q == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      s_en_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_en) begin
            if (dec_unmapped) begin
              state_q <= ERR;
            end else begin
              req_q   <= req_d;
              sel_q   <= dec_sel;
              s_en_q  <= dec_sel;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          s_en_q  <= '0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (ack_hit || tmo_hit) begin
            state_q <= IDLE;
          end
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) begin
        rd_mux = rd_mux | s_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign m_ready   = ack_hit | tmo_hit | err_done;
  assign m_err     = tmo_hit | err_done;
  assign m_busy    = (state_q != IDLE);
  assign m_rd_data = ack_hit ? rd_mux : (m_err ? ERR_DATA : '0);

  assign s_en      = s_en_q;
  assign s_rdwr    = req_q.rdwr;
  assign s_addr    = req_q.addr;
  assign s_wr_data = req_q.wr_data;
  assign s_mask    = req_q.mask;

`ifdef SYS_BUS_ERR_LOG_EN
  // Unmapped requests never load req_q, so their raw address is held here.
  logic [ADDR_W-1:0] unm_addr_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic              err_cause_q, err_valid_q;
  logic              err_evt;

  assign err_evt = tmo_hit | err_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unm_addr_q <= '0;
    end else if ((state_q == IDLE) && m_en && dec_unmapped) begin
      unm_addr_q <= m_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_addr_q  <= '0;
      err_cause_q <= 1'b0;
      err_valid_q <= 1'b0;
    end else if (err_evt && (!err_valid_q || err_clr)) begin
      err_addr_q  <= err_done ? unm_addr_q : req_q.addr;
      err_cause_q <= tmo_hit;
      err_valid_q <= 1'b1;
    end else if (err_clr) begin
      err_valid_q <= 1'b0;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_cause = err_cause_q;
  assign err_valid = err_valid_q;
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^m_addr[1:0];
`endif

endmodule
